// File: rtl/pll_ctrl_pkg.sv
// Shared types, defaults and Gray-code helpers for the PLL lock sequencer.
package pll_ctrl_pkg;

    localparam int unsigned DEF_RATIO      = 5;
    localparam int unsigned DEF_WIN_CYC    = 16;
    localparam int unsigned DEF_TOL        = 2;
    localparam int unsigned DEF_SETTLE_CYC = 64;
    localparam int unsigned DEF_LOCK_HITS  = 4;
    localparam int unsigned DEF_LOSS_HITS  = 2;
    localparam int unsigned DEF_MAX_WIN    = 32;
    localparam int unsigned DEF_CNT_W      = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        MEASURE = 3'd2,
        LOCKED  = 3'd3,
        FAIL    = 3'd4
    } pll_state_e;

    // Zero-extended operands convert correctly, so callers cast to their width.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin[31] = gray[31];
        for (int i = 30; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/pll_lock_ctrl_if.sv
// Control/status bundle between the TX clock manager and the PLL sequencer.
interface pll_lock_ctrl_if #(
    parameter int unsigned CNT_W = pll_ctrl_pkg::DEF_CNT_W
) ();
    logic             Enable;
    logic             Pll_En;
    logic             Pll_Lock;
    logic             Clk_En;
    logic             Lock_Lost;
    logic             Lock_Fail;
    logic [CNT_W-1:0] Meas_Cnt;

    modport master (
        output Enable,
        input  Pll_En, Pll_Lock, Clk_En, Lock_Lost, Lock_Fail, Meas_Cnt
    );

    modport slave (
        input  Enable,
        output Pll_En, Pll_Lock, Clk_En, Lock_Lost, Lock_Fail, Meas_Cnt
    );
endinterface

// File: rtl/pll_gray_cnt.sv
// Free-running Gray counter in the Bit_Rate_10 domain; read from Ref_Clk.
module pll_gray_cnt
    import pll_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             Bit_Rate_10,
    input  logic             i_pll_en,
    output logic [CNT_W-1:0] o_cnt_gray
);

    logic             r_en_meta;
    logic             r_en_sync;
    logic [CNT_W-1:0] r_bin;
    logic [CNT_W-1:0] r_gray;
    logic [CNT_W-1:0] w_bin_inc;

    assign w_bin_inc = r_bin + CNT_W'(1);

    // Bring the slow-domain enable into the fast clock domain
    always_ff @(posedge Bit_Rate_10) begin
        r_en_meta <= i_pll_en;
        r_en_sync <= r_en_meta;
    end

    // Count fast edges; held at zero while the PLL is disabled
    always_ff @(posedge Bit_Rate_10) begin
        if (!r_en_sync) begin
            r_bin  <= '0;
            r_gray <= '0;
        end else begin
            r_bin  <= w_bin_inc;
            r_gray <= CNT_W'(bin2gray(32'(w_bin_inc)));
        end
    end

    assign o_cnt_gray = r_gray;

endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL enable/lock sequencer: settle, measure Bit_Rate_10 per window, lock, gate clocks.
module pll_lock_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int unsigned RATIO      = DEF_RATIO,
    parameter int unsigned WIN_CYC    = DEF_WIN_CYC,
    parameter int unsigned TOL        = DEF_TOL,
    parameter int unsigned SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int unsigned LOCK_HITS  = DEF_LOCK_HITS,
    parameter int unsigned LOSS_HITS  = DEF_LOSS_HITS,
    parameter int unsigned MAX_WIN    = DEF_MAX_WIN,
    parameter int unsigned CNT_W      = DEF_CNT_W
) (
    input  logic           Ref_Clk,
    input  logic           Rst,
    input  logic           Bit_Rate_10,
    pll_lock_ctrl_if.slave bus
);

    localparam int unsigned NOM_CNT = RATIO * WIN_CYC;
    localparam int unsigned LO_CNT  = (NOM_CNT > TOL) ? (NOM_CNT - TOL) : 0;
    localparam int unsigned HI_CNT  = NOM_CNT + TOL;
    localparam int unsigned SET_W   = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int unsigned WIN_W   = (WIN_CYC > 1) ? $clog2(WIN_CYC) : 1;
    localparam int unsigned HIT_W   = $clog2(LOCK_HITS + 1);
    localparam int unsigned MISS_W  = $clog2(LOSS_HITS + 1);
    localparam int unsigned TOT_W   = $clog2(MAX_WIN + 1);

    pll_state_e        r_state,      w_state_nxt;
    logic [SET_W-1:0]  r_settle_cnt, w_settle_nxt;
    logic [WIN_W-1:0]  r_win_cnt,    w_win_nxt;
    logic [CNT_W-1:0]  r_prev,       w_prev_nxt;
    logic [HIT_W-1:0]  r_hit,        w_hit_nxt;
    logic [MISS_W-1:0] r_miss,       w_miss_nxt;
    logic [TOT_W-1:0]  r_total,      w_total_nxt;
    logic [CNT_W-1:0]  r_meas_cnt,   w_meas_nxt;
    logic              r_pll_en,     w_pll_en_nxt;
    logic              r_pll_lock,   w_pll_lock_nxt;
    logic              r_clk_en,     w_clk_en_nxt;
    logic              r_lock_lost,  w_lock_lost_nxt;
    logic              r_lock_fail,  w_lock_fail_nxt;

    logic [CNT_W-1:0]  w_cnt_gray;
    logic [CNT_W-1:0]  r_gray_s1;
    logic [CNT_W-1:0]  r_gray_s2;
    logic [CNT_W-1:0]  w_snap;
    logic [CNT_W-1:0]  w_delta;
    logic              w_good;
    logic              w_win_close;

    pll_gray_cnt #(
        .CNT_W (CNT_W)
    ) u_gray_cnt (
        .Bit_Rate_10 (Bit_Rate_10),
        .i_pll_en    (r_pll_en),
        .o_cnt_gray  (w_cnt_gray)
    );

    // Two-flop synchronizer for the Gray count; its fixed latency cancels in the delta
    always_ff @(posedge Ref_Clk) begin
        if (!Rst) begin
            r_gray_s1 <= '0;
            r_gray_s2 <= '0;
        end else begin
            r_gray_s1 <= w_cnt_gray;
            r_gray_s2 <= r_gray_s1;
        end
    end

    assign w_snap      = CNT_W'(gray2bin(32'(r_gray_s2)));
    assign w_delta     = w_snap - r_prev;
    assign w_good      = (w_delta >= CNT_W'(LO_CNT)) && (w_delta <= CNT_W'(HI_CNT));
    assign w_win_close = (r_win_cnt == WIN_W'(WIN_CYC - 1));

    // State and bookkeeping registers
    always_ff @(posedge Ref_Clk) begin
        if (!Rst) begin
            r_state      <= IDLE;
            r_settle_cnt <= '0;
            r_win_cnt    <= '0;
            r_prev       <= '0;
            r_hit        <= '0;
            r_miss       <= '0;
            r_total      <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_settle_cnt <= w_settle_nxt;
            r_win_cnt    <= w_win_nxt;
            r_prev       <= w_prev_nxt;
            r_hit        <= w_hit_nxt;
            r_miss       <= w_miss_nxt;
            r_total      <= w_total_nxt;
        end
    end

    // Next state, window evaluation and registered-output decode
    always_comb begin
        w_state_nxt     = r_state;
        w_settle_nxt    = r_settle_cnt;
        w_win_nxt       = r_win_cnt;
        w_prev_nxt      = r_prev;
        w_hit_nxt       = r_hit;
        w_miss_nxt      = r_miss;
        w_total_nxt     = r_total;
        w_meas_nxt      = r_meas_cnt;
        w_lock_lost_nxt = 1'b0;
        w_pll_en_nxt    = 1'b0;
        w_pll_lock_nxt  = 1'b0;
        w_clk_en_nxt    = 1'b0;
        w_lock_fail_nxt = 1'b0;

        case (r_state)
            IDLE: begin
                w_settle_nxt = '0;
                w_win_nxt    = '0;
                w_hit_nxt    = '0;
                w_miss_nxt   = '0;
                w_total_nxt  = '0;
                if (bus.Enable) begin
                    w_state_nxt = SETTLE;
                end
            end

            SETTLE: begin
                w_settle_nxt = r_settle_cnt + SET_W'(1);
                if (r_settle_cnt == SET_W'(SETTLE_CYC - 1)) begin
                    w_state_nxt  = MEASURE;
                    w_settle_nxt = '0;
                    w_win_nxt    = '0;
                    w_prev_nxt   = w_snap;
                end
            end

            MEASURE: begin
                w_win_nxt = w_win_close ? '0 : (r_win_cnt + WIN_W'(1));
                if (w_win_close) begin
                    w_meas_nxt  = w_delta;
                    w_prev_nxt  = w_snap;
                    w_total_nxt = r_total + TOT_W'(1);
                    w_hit_nxt   = w_good ? (r_hit + HIT_W'(1)) : '0;
                    if (w_good && (r_hit == HIT_W'(LOCK_HITS - 1))) begin
                        w_state_nxt = LOCKED;
                        w_miss_nxt  = '0;
                    end else if (r_total == TOT_W'(MAX_WIN - 1)) begin
                        w_state_nxt = FAIL;
                    end
                end
            end

            LOCKED: begin
                w_win_nxt = w_win_close ? '0 : (r_win_cnt + WIN_W'(1));
                if (w_win_close) begin
                    w_meas_nxt = w_delta;
                    w_prev_nxt = w_snap;
                    if (w_good) begin
                        w_miss_nxt = '0;
                    end else if (r_miss == MISS_W'(LOSS_HITS - 1)) begin
                        w_state_nxt     = MEASURE;
                        w_miss_nxt      = '0;
                        w_hit_nxt       = '0;
                        w_total_nxt     = '0;
                        w_lock_lost_nxt = 1'b1;
                    end else begin
                        w_miss_nxt = r_miss + MISS_W'(1);
                    end
                end
            end

            FAIL: begin
                w_state_nxt = FAIL;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Dropping Enable wins over everything, including a closing window
        if (!bus.Enable) begin
            w_state_nxt     = IDLE;
            w_settle_nxt    = '0;
            w_win_nxt       = '0;
            w_hit_nxt       = '0;
            w_miss_nxt      = '0;
            w_total_nxt     = '0;
            w_prev_nxt      = r_prev;
            w_meas_nxt      = r_meas_cnt;
            w_lock_lost_nxt = 1'b0;
        end

        w_pll_en_nxt    = (w_state_nxt == SETTLE) || (w_state_nxt == MEASURE) ||
                          (w_state_nxt == LOCKED);
        w_pll_lock_nxt  = (w_state_nxt == LOCKED);
        w_clk_en_nxt    = (w_state_nxt == LOCKED);
        w_lock_fail_nxt = (w_state_nxt == FAIL);
    end

    // Output registers
    always_ff @(posedge Ref_Clk) begin
        if (!Rst) begin
            r_pll_en    <= 1'b0;
            r_pll_lock  <= 1'b0;
            r_clk_en    <= 1'b0;
            r_lock_lost <= 1'b0;
            r_lock_fail <= 1'b0;
            r_meas_cnt  <= '0;
        end else begin
            r_pll_en    <= w_pll_en_nxt;
            r_pll_lock  <= w_pll_lock_nxt;
            r_clk_en    <= w_clk_en_nxt;
            r_lock_lost <= w_lock_lost_nxt;
            r_lock_fail <= w_lock_fail_nxt;
            r_meas_cnt  <= w_meas_nxt;
        end
    end

    assign bus.Pll_En    = r_pll_en;
    assign bus.Pll_Lock  = r_pll_lock;
    assign bus.Clk_En    = r_clk_en;
    assign bus.Lock_Lost = r_lock_lost;
    assign bus.Lock_Fail = r_lock_fail;
    assign bus.Meas_Cnt  = r_meas_cnt;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Bench for pll_lock_ctrl: window-level reference model driven by per-window clock periods.
`timescale 1ps/1ps
module tb_pll_lock_ctrl;

    localparam int REF_PER   = 10000;
    localparam int RATIO     = 5;
    localparam int WIN       = 16;
    localparam int TOL       = 2;
    localparam int SETTLE    = 64;
    localparam int LOCK_HITS = 4;
    localparam int LOSS_HITS = 2;
    localparam int MAX_WIN   = 32;

    logic Ref_Clk     = 1'b0;
    logic Bit_Rate_10 = 1'b0;
    logic Rst         = 1'b0;
    int   fast_half   = 1000;

    pll_lock_ctrl_if #(.CNT_W(8)) bus ();

    pll_lock_ctrl dut (
        .Ref_Clk     (Ref_Clk),
        .Rst         (Rst),
        .Bit_Rate_10 (Bit_Rate_10),
        .bus         (bus)
    );

    always #(REF_PER/2) Ref_Clk = ~Ref_Clk;

    // Fast clock; a zero half-period parks it low
    always begin
        if (fast_half == 0) begin
            Bit_Rate_10 = 1'b0;
            wait (fast_half != 0);
        end else begin
            #(fast_half);
            if (fast_half != 0) Bit_Rate_10 = ~Bit_Rate_10;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input int obs, input int exp, input int tol = 0);
        n_checks++;
        if (obs < exp - tol || obs > exp + tol) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d, want %0d (+/-%0d)", tag, $time, obs, exp, tol);
        end
    endtask

    // Reference model: session timeline in Ref_Clk edges and per-window verdicts
    bit m_on, m_locked, m_fail, m_lost;
    int m_t, m_hit, m_total, m_miss;
    int m_meas_nom = 0;
    int m_meas_tol = 0;
    int win_per [0:63];
    int plan [$];

    function automatic int nominal(input int per);
        return (per == 0) ? 0 : (WIN * REF_PER + per / 2) / per;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic close_window(input int k);
        int  nom;
        bit  good;
        nom  = nominal((k < 64) ? win_per[k] : 0);
        good = iabs(nom - RATIO * WIN) <= TOL;
        m_meas_nom = nom;
        m_meas_tol = 2;
        if (m_locked) begin
            m_miss = good ? 0 : m_miss + 1;
            if (m_miss == LOSS_HITS) begin
                m_locked = 0; m_hit = 0; m_total = 0; m_miss = 0; m_lost = 1;
            end
        end else begin
            m_total++;
            m_hit = good ? m_hit + 1 : 0;
            if (m_hit == LOCK_HITS) begin
                m_locked = 1; m_miss = 0;
            end else if (m_total == MAX_WIN) begin
                m_fail = 1;
            end
        end
    endtask

    task automatic mdl_edge();
        m_lost = 0;
        if (!Rst) begin
            m_on = 0; m_locked = 0; m_fail = 0; m_meas_nom = 0; m_meas_tol = 0;
        end else if (!bus.Enable) begin
            m_on = 0; m_locked = 0; m_fail = 0;
        end else if (!m_on) begin
            m_on = 1; m_t = 0; m_hit = 0; m_total = 0; m_miss = 0;
        end else begin
            m_t++;
            if (!m_fail && m_t >= SETTLE + WIN && (m_t - SETTLE) % WIN == 0)
                close_window((m_t - SETTLE) / WIN - 1);
        end
    endtask

    // Apply the next window's period right as the previous window's sample is taken
    task automatic sched();
        int k;
        int per;
        if (m_on && !m_fail && m_t >= SETTLE - 2 && (m_t - (SETTLE - 2)) % WIN == 0) begin
            k   = (m_t - (SETTLE - 2)) / WIN;
            per = (k < plan.size()) ? plan[k] : plan[plan.size() - 1];
            if (k < 64) win_per[k] = per;
            fast_half = per / 2;
        end
    endtask

    task automatic step();
        @(posedge Ref_Clk);
        mdl_edge();
        sched();
        @(negedge Ref_Clk);
        check("pll_en",    int'(bus.Pll_En),    int'(m_on && !m_fail));
        check("pll_lock",  int'(bus.Pll_Lock),  int'(m_locked));
        check("clk_en",    int'(bus.Clk_En),    int'(m_locked));
        check("lock_lost", int'(bus.Lock_Lost), int'(m_lost));
        check("lock_fail", int'(bus.Lock_Fail), int'(m_fail));
        check("meas_cnt",  int'(bus.Meas_Cnt),  m_meas_nom, m_meas_tol);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        bus.Enable = 1'b0;

        // Reset
        run(2);
        Rst = 1'b1;
        run(3);

        // Nominal lock, counter wraps, loss on stopped clock, relock, drop while locked
        plan = '{2000, 2000, 2000, 2000, 2000, 2000, 2000, 2000,
                 0, 0, 0, 2000, 2000, 2000, 2000, 2000, 2000};
        bus.Enable = 1'b1;
        run(SETTLE + WIN * 17 + 5);
        bus.Enable = 1'b0;
        run(3);

        // Slow PLL never locks and fails after MAX_WIN windows
        plan = '{2200};
        bus.Enable = 1'b1;
        run(SETTLE + WIN * MAX_WIN + 4);
        run(5);
        bus.Enable = 1'b0;
        run(3);

        // Drop mid-MEASURE
        plan = '{2000};
        bus.Enable = 1'b1;
        run(SETTLE + WIN * 2 + 7);
        bus.Enable = 1'b0;
        run(3);

        // Drop on the same edge a distinctive window closes: that window is discarded
        plan = '{2000, 2000, 1800};
        bus.Enable = 1'b1;
        run(SETTLE + WIN * 3);
        bus.Enable = 1'b0;
        run(4);

        // Random period sequences with a random drop point
        for (int r = 0; r < 3; r++) begin
            plan.delete();
            for (int i = 0; i < 24; i++) begin
                case ($urandom_range(0, 5))
                    0, 1, 2: plan.push_back(2000);
                    3:       plan.push_back(2200);
                    4:       plan.push_back(1800);
                    default: plan.push_back(0);
                endcase
            end
            bus.Enable = 1'b1;
            run(SETTLE + WIN * $urandom_range(2, 20) + $urandom_range(0, 15));
            bus.Enable = 1'b0;
            run(2);
        end

        // Reset while locked
        plan = '{2000};
        bus.Enable = 1'b1;
        run(SETTLE + WIN * 5 + 3);
        Rst = 1'b0;
        run(2);
        bus.Enable = 1'b0;
        Rst = 1'b1;
        run(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
